uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART core.
- Captures each completed byte from the core's rx data and rx done outputs into a circular FIFO.
- Presents the buffered bytes to the bus register interface as a first-word-fall-through read port.
- Provides occupancy, overflow status and a watermark interrupt so software does not need to poll every byte.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2
DATA_W, 8, byte width; matches the core's rx data width
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk_i  input  1  system clock; all state updates on rising edge
rst_i  input  1  asynchronous reset, active-high
rx_data_i  input  DATA_W  received byte from the UART core
rx_done_i  input  1  core receive-done flag; either a level or a pulse, depending on the core's config
rd_en_i  input  1  pop request from the bus side
rd_data_o  output  DATA_W  head-of-FIFO byte (first-word-fall-through)
empty_o  output  1  FIFO holds no entries
full_o  output  1  FIFO holds DEPTH entries
count_o  output  CW  current occupancy, 0..DEPTH
watermark_i  input  CW  interrupt threshold; 0 disables the interrupt
irq_o  output  1  level interrupt: watermark reached
overflow_o  output  1  sticky: a byte was dropped because the FIFO was full
ovf_clr_i  input  1  clears overflow_o
flush_i  input  1  synchronous discard of all entries
timeout_cycles_i  input  16  idle-timeout threshold (used only with the optional feature)
timeout_o  output  1  sticky idle-timeout flag (used only with the optional feature)

Behaviour:
- Reset (asynchronous, rst_i=1):
  - wr_ptr=0, rd_ptr=0, count_o=0, empty_o=1, full_o=0.
  - overflow_o=0, irq_o=0, timeout_o=0, rd_data_o=0.
  - Edge register done_q=1, so a done level already high when reset is released is not captured.
  - Memory contents are not reset.
- Push detect:
  - push_req = rx_done_i & ~done_q; done_q <= rx_done_i every cycle.
  - Exactly one push per 0->1 transition of rx_done_i, whether the core drives it as a pulse or as a sticky level.
  - rx_data_i is sampled in the same cycle as push_req.
- Pop:
  - pop = rd_en_i & ~empty_o.
  - rd_en_i while empty is ignored: no pointer move, no error flag.
- Write: if push_req and (not full, or pop in the same cycle), write mem[wr_ptr] and increment wr_ptr modulo DEPTH.
- Read: on pop, increment rd_ptr modulo DEPTH.
- Count update:
  - count_o +1 on push only, -1 on pop only.
  - Unchanged when both or neither occur.
- Status flags: full_o = (count_o==DEPTH); empty_o = (count_o==0).
- Output: rd_data_o = mem[rd_ptr] while not empty, 0 while empty.
  - A byte pushed into an empty FIFO appears on rd_data_o in the cycle after the push.
- Boundary cases:
  - Full, push with no pop: byte dropped, pointers unchanged, overflow_o set next cycle.
  - Full, push and pop together: both accepted, count stays DEPTH, no overflow.
  - Empty, push and rd_en together: push accepted, pop ignored, count becomes 1.
  - Pointer wrap: DEPTH-1 -> 0 with no loss of data.
- Overflow flag:
  - Set by a dropped push; cleared by ovf_clr_i.
  - Set and clear in the same cycle: set wins.
  - Not affected by flush_i.
- Flush:
  - flush_i=1: next cycle wr_ptr=rd_ptr=0 and count_o=0.
  - Flush has priority over push and pop in the same cycle; a push in the flush cycle is dropped and does not set overflow.
- Interrupt: irq_o = (watermark_i!=0) && (count_o>=watermark_i); combinational from registered state, no added latency.
- There are no other states; the FIFO state is fully defined by the pointers and count.

Optional Feature:
- Macro: UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter clears on any push, pop, flush or reset.
  - Otherwise it increments (saturating) while the FIFO is not empty.
  - When the counter equals timeout_cycles_i and timeout_cycles_i!=0, timeout_o is set.
  - timeout_o is sticky until the next pop, flush or reset.
  - irq_o becomes the watermark condition OR timeout_o.
  - Purpose: tail bytes below the watermark still raise an interrupt.
- Not defined:
  - Ports remain present; timeout_cycles_i is ignored.
  - timeout_o is tied to 0 and irq_o is the watermark condition only.
  - No counter logic is instantiated.

Test Plan:
- Reset release with rx_done_i held 1 -> count_o=0, empty_o=1; a later 1->0->1 on rx_done_i with byte 0xA5 -> count_o=1, rd_data_o=0xA5 on the next cycle.
- 16 pushes 0x00..0x0F, then a 17th push 0xFF -> full_o=1, count_o=16, overflow_o=1; popping 16 times returns 0x00..0x0F in order; ovf_clr_i -> overflow_o=0.
- Full FIFO, push 0x55 and pop in the same cycle -> count stays 16, no overflow; the final popped byte is 0x55; covers wr/rd pointer wrap.
- watermark_i=4: pushes 1..3 -> irq_o=0; 4th push -> irq_o=1; one pop -> irq_o=0; watermark_i=0 -> irq_o never asserts.
- 5 bytes buffered, flush_i together with a push of 0x77 -> next cycle count_o=0, empty_o=1, rd_data_o=0, overflow_o unchanged.
- With UART_RX_FIFO_TIMEOUT_EN, timeout_cycles_i=100, one byte pushed and no pops -> timeout_o=1 and irq_o=1 about 100 cycles after the push; one pop -> timeout_o=0. Without the macro -> timeout_o stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detected byte capture, first-word-fall-through read port,
// occupancy/overflow status and watermark IRQ. Optional idle timeout: UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_done_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [CW-1:0]     count_o,
  input  logic [CW-1:0]     watermark_i,
  output logic              irq_o,
  output logic              overflow_o,
  input  logic              ovf_clr_i,
  input  logic              flush_i,
  input  logic [15:0]       timeout_cycles_i,
  output logic              timeout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              done_q;
  logic              push_req, pop, push_ok, wm_hit;

  assign empty_o  = (count == '0);
  assign full_o   = (count == CW'(DEPTH));
  assign count_o  = count;
  assign push_req = rx_done_i & ~done_q;
  assign pop      = rd_en_i & ~empty_o;
  assign push_ok  = push_req & (~full_o | pop);
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr];
  assign wm_hit   = (watermark_i != '0) && (count >= watermark_i);

  // done_q resets high so a level already asserted at reset release is not a new byte
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q     <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      done_q <= rx_done_i;
      if (push_req && full_o && !pop && !flush_i)
        overflow_o <= 1'b1;
      else if (ovf_clr_i)
        overflow_o <= 1'b0;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)      count <= count + CW'(1);
        else if (pop && !push_ok) count <= count - CW'(1);
      end
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem[wr_ptr] <= rx_data_i;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] idle;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle      <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (push_req || pop || flush_i)
        idle <= '0;
      else if (!empty_o && idle != 16'hFFFF)
        idle <= idle + 16'd1;
      if (pop || flush_i)
        timeout_o <= 1'b0;
      else if (timeout_cycles_i != '0 && idle == timeout_cycles_i)
        timeout_o <= 1'b1;
    end
  end

  assign irq_o = wm_hit | timeout_o;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles_i;
  assign timeout_o      = 1'b0;
  assign irq_o          = wm_hit;
`endif

endmodule
